// File: rtl/axi4_burst_mem.sv
// AXI4 slave backed by an internal word array, with independent write and read
// burst engines supporting FIXED, INCR and WRAP bursts and SLVERR on illegal bursts.
module axi4_burst_mem #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int MEMORY_DEPTH = 1024,
   parameter int ID_WIDTH     = 4
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [ID_WIDTH-1:0]     AWID,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic [7:0]              AWLEN,
   input  logic [2:0]              AWSIZE,
   input  logic [1:0]              AWBURST,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WLAST,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [ID_WIDTH-1:0]     BID,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ID_WIDTH-1:0]     ARID,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic [7:0]              ARLEN,
   input  logic [2:0]              ARSIZE,
   input  logic [1:0]              ARBURST,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [ID_WIDTH-1:0]     RID,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RLAST,
   output logic                    RVALID,
   input  logic                    RREADY
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LG     = $clog2(STRB_W);
   localparam int IW     = $clog2(MEMORY_DEPTH);
   localparam int EW     = ADDR_WIDTH + 9;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_t;

   function automatic logic [ADDR_WIDTH-1:0] next_addr(
      input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
      input logic [2:0] size, input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] inc, mask;
      inc  = addr + (ADDR_WIDTH'(1) << size);
      mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      case (burst)
         2'b00:   next_addr = addr;
         2'b10:   next_addr = (addr & ~mask) | (inc & mask);
         default: next_addr = inc;
      endcase
   endfunction

   // Evaluated once at address capture; widened so that no intermediate sum wraps.
   function automatic logic burst_err(
      input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
      input logic [2:0] size, input logic [1:0] burst);
      logic [EW-1:0] a, bytes, last;
      logic err;
      a     = EW'(addr);
      bytes = (EW'(len) + EW'(1)) << size;
      err   = 1'b0;
      last  = a;
      case (burst)
         2'b00: last = a;
         2'b01: begin
            last = a + bytes - EW'(1);
            if (a[EW-1:12] != last[EW-1:12]) err = 1'b1;
         end
         2'b10: begin
            last = (a & ~(bytes - EW'(1))) + bytes - EW'(1);
            if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) err = 1'b1;
            if ((a & ((EW'(1) << size) - EW'(1))) != EW'(0)) err = 1'b1;
         end
         default: err = 1'b1;
      endcase
      if (int'(size) > LG) err = 1'b1;
      if ((last >> LG) >= EW'(MEMORY_DEPTH)) err = 1'b1;
      burst_err = err;
   endfunction

   logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

   w_state_t              w_state, w_next;
   r_state_t              r_state, r_next;
   logic [ID_WIDTH-1:0]   aw_id, ar_id;
   logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
   logic [7:0]            aw_len, ar_len, w_cnt, r_cnt;
   logic [2:0]            aw_size, ar_size;
   logic [1:0]            aw_burst, ar_burst;
   logic                  w_err, r_err, wlast_err, mem_we;

   assign AWREADY = (w_state == W_IDLE);
   assign WREADY  = (w_state == W_DATA);
   assign BVALID  = (w_state == W_RESP);
   assign ARREADY = (r_state == R_IDLE);
   assign RVALID  = (r_state == R_DATA);
   assign mem_we  = (w_state == W_DATA) && WVALID && !w_err && !ARESET;

   always_ff @(posedge ACLK) begin
      if (ARESET) w_state <= W_IDLE;
      else        w_state <= w_next;
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (AWVALID) w_next = W_DATA; else w_next = W_IDLE;
         W_DATA:  if (WVALID && w_cnt == aw_len) w_next = W_RESP; else w_next = W_DATA;
         W_RESP:  if (BREADY) w_next = W_IDLE; else w_next = W_RESP;
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_id <= '0; aw_addr <= '0; aw_len <= 8'd0; aw_size <= 3'd0; aw_burst <= 2'd0;
         w_cnt <= 8'd0; w_err <= 1'b0; wlast_err <= 1'b0; BID <= '0; BRESP <= 2'b00;
      end else if (w_state == W_IDLE && AWVALID) begin
         aw_id <= AWID; aw_addr <= AWADDR; aw_len <= AWLEN; aw_size <= AWSIZE; aw_burst <= AWBURST;
         w_cnt <= 8'd0; wlast_err <= 1'b0;
         w_err <= burst_err(AWADDR, AWLEN, AWSIZE, AWBURST);
      end else if (w_state == W_DATA && WVALID) begin
         w_cnt   <= w_cnt + 8'd1;
         aw_addr <= next_addr(aw_addr, aw_len, aw_size, aw_burst);
         if (w_cnt == aw_len) begin
            BID   <= aw_id;
            BRESP <= (w_err || wlast_err || !WLAST) ? 2'b10 : 2'b00;
         end else if (WLAST) begin
            wlast_err <= 1'b1;
         end
      end
   end

   // Byte-lane write port; gated by ARESET so an aborted burst stops writing on the reset edge.
   always_ff @(posedge ACLK) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (WSTRB[b]) mem[aw_addr[LG +: IW]][8*b +: 8] <= WDATA[8*b +: 8];
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) r_state <= R_IDLE;
      else        r_state <= r_next;
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ARVALID) r_next = R_FETCH; else r_next = R_IDLE;
         R_FETCH: r_next = R_DATA;
         R_DATA:  if (RREADY) r_next = RLAST ? R_IDLE : R_FETCH; else r_next = R_DATA;
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         ar_id <= '0; ar_addr <= '0; ar_len <= 8'd0; ar_size <= 3'd0; ar_burst <= 2'd0;
         r_cnt <= 8'd0; r_err <= 1'b0;
         RID <= '0; RDATA <= '0; RRESP <= 2'b00; RLAST <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: if (ARVALID) begin
               ar_id <= ARID; ar_addr <= ARADDR; ar_len <= ARLEN; ar_size <= ARSIZE; ar_burst <= ARBURST;
               r_cnt <= 8'd0;
               r_err <= burst_err(ARADDR, ARLEN, ARSIZE, ARBURST);
            end
            R_FETCH: begin
               RDATA <= r_err ? '0 : mem[ar_addr[LG +: IW]];
               RRESP <= r_err ? 2'b10 : 2'b00;
               RID   <= ar_id;
               RLAST <= (r_cnt == ar_len);
            end
            R_DATA: if (RREADY) begin
               RLAST   <= 1'b0;
               r_cnt   <= r_cnt + 8'd1;
               ar_addr <= next_addr(ar_addr, ar_len, ar_size, ar_burst);
            end
            default: r_cnt <= 8'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_burst_mem.sv
// Directed bench for axi4_burst_mem: burst types, strobes, error bursts, early WLAST, mid-burst reset.
module tb_axi4_burst_mem;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [3:0]  AWID, ARID, BID, RID;
   logic [15:0] AWADDR, ARADDR;
   logic [7:0]  AWLEN, ARLEN;
   logic [2:0]  AWSIZE, ARSIZE;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
   logic [31:0] WDATA, RDATA;
   logic [3:0]  WSTRB;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] wdat [256];
   logic [31:0] rexp [256];

   axi4_burst_mem dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                     input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                     input int last_at, input logic [1:0] exp_resp);
      chk("awready_idle", 64'(AWREADY), 64'd1);
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
      @(negedge ACLK);
      AWVALID = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         chk("wready", 64'(WREADY), 64'd1);
         WDATA = wdat[i]; WSTRB = strb; WLAST = (i == last_at); WVALID = 1'b1;
         @(negedge ACLK);
      end
      WVALID = 1'b0; WLAST = 1'b0;
      chk("wready_done", 64'(WREADY), 64'd0);
      chk("bvalid", 64'(BVALID), 64'd1);
      chk("bresp", 64'(BRESP), 64'(exp_resp));
      chk("bid", 64'(BID), 64'(id));
      BREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0;
      chk("bvalid_clr", 64'(BVALID), 64'd0);
      chk("awready_back", 64'(AWREADY), 64'd1);
   endtask

   task automatic rd(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                     input logic [2:0] size, input logic [1:0] burst, input logic [1:0] exp_resp);
      chk("arready_idle", 64'(ARREADY), 64'd1);
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
      @(negedge ACLK);
      ARVALID = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         chk("rvalid_bubble", 64'(RVALID), 64'd0);
         @(negedge ACLK);
         chk("rvalid", 64'(RVALID), 64'd1);
         chk("rdata", 64'(RDATA), 64'(rexp[i]));
         chk("rresp", 64'(RRESP), 64'(exp_resp));
         chk("rid", 64'(RID), 64'(id));
         chk("rlast", 64'(RLAST), 64'(i == int'(len)));
         if (i == 0) begin
            @(negedge ACLK);
            chk("rvalid_hold", 64'(RVALID), 64'd1);
            chk("rdata_hold", 64'(RDATA), 64'(rexp[0]));
            chk("rlast_hold", 64'(RLAST), 64'(len == 8'd0));
         end
         RREADY = 1'b1;
         @(negedge ACLK);
         RREADY = 1'b0;
      end
      chk("arready_back", 64'(ARREADY), 64'd1);
   endtask

   initial begin
      ARESET = 1'b1;
      AWID = 4'd0; AWADDR = 16'd0; AWLEN = 8'd0; AWSIZE = 3'd0; AWBURST = 2'd0; AWVALID = 1'b0;
      WDATA = 32'd0; WSTRB = 4'd0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      ARID = 4'd0; ARADDR = 16'd0; ARLEN = 8'd0; ARSIZE = 3'd0; ARBURST = 2'd0; ARVALID = 1'b0;
      RREADY = 1'b0;
      repeat (2) @(negedge ACLK);
      chk("rst_awready", 64'(AWREADY), 64'd1);
      chk("rst_arready", 64'(ARREADY), 64'd1);
      chk("rst_wready", 64'(WREADY), 64'd0);
      chk("rst_bvalid", 64'(BVALID), 64'd0);
      chk("rst_rvalid", 64'(RVALID), 64'd0);
      chk("rst_rlast", 64'(RLAST), 64'd0);
      chk("rst_bresp", 64'(BRESP), 64'd0);
      chk("rst_rresp", 64'(RRESP), 64'd0);
      chk("rst_bid", 64'(BID), 64'd0);
      chk("rst_rid", 64'(RID), 64'd0);
      chk("rst_rdata", 64'(RDATA), 64'd0);
      ARESET = 1'b0;
      @(negedge ACLK);

      // INCR write/read round trip
      for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); rexp[i] = 32'(i + 1); end
      wr(4'd3, 16'h0010, 8'd3, 3'd2, 2'b01, 4'hF, 3, 2'b00);
      rd(4'd5, 16'h0010, 8'd3, 3'd2, 2'b01, 2'b00);

      // WRAP write lands at 0x38, 0x3C, 0x30, 0x34
      wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
      wr(4'd4, 16'h0038, 8'd3, 3'd2, 2'b10, 4'hF, 3, 2'b00);
      for (int i = 0; i < 4; i++) rexp[i] = 32'h33;
      rd(4'd6, 16'h0030, 8'd3, 3'd2, 2'b00, 2'b00);
      rexp[0] = 32'h33; rexp[1] = 32'h44; rexp[2] = 32'h11; rexp[3] = 32'h22;
      rd(4'd7, 16'h0030, 8'd3, 3'd2, 2'b01, 2'b00);

      // Byte strobes on a zeroed word, single-beat bursts
      wdat[0] = 32'h0;
      wr(4'd1, 16'h0100, 8'd0, 3'd2, 2'b01, 4'hF, 0, 2'b00);
      wdat[0] = 32'hAABBCCDD;
      wr(4'd2, 16'h0100, 8'd0, 3'd2, 2'b01, 4'b0101, 0, 2'b00);
      rexp[0] = 32'h00BB00DD;
      rd(4'd2, 16'h0100, 8'd0, 3'd2, 2'b01, 2'b00);

      // 4 KB crossing write leaves memory untouched; out-of-range read returns zeros
      wdat[0] = 32'hA0; wdat[1] = 32'hA1;
      wr(4'd8, 16'h0FF8, 8'd1, 3'd2, 2'b01, 4'hF, 1, 2'b00);
      for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 5);
      wr(4'd9, 16'h0FF8, 8'd3, 3'd2, 2'b01, 4'hF, 3, 2'b10);
      rexp[0] = 32'hA0; rexp[1] = 32'hA1;
      rd(4'd9, 16'h0FF8, 8'd1, 3'd2, 2'b01, 2'b00);
      for (int i = 0; i < 4; i++) rexp[i] = 32'h0;
      rd(4'd10, 16'h1000, 8'd3, 3'd2, 2'b01, 2'b10);
      wdat[0] = 32'hDEAD;
      wr(4'd11, 16'h0030, 8'd0, 3'd2, 2'b11, 4'hF, 0, 2'b10);
      rd(4'd12, 16'h0030, 8'd2, 3'd2, 2'b10, 2'b10);
      rd(4'd13, 16'h0030, 8'd0, 3'd3, 2'b01, 2'b10);
      rexp[0] = 32'h33;
      rd(4'd14, 16'h0030, 8'd0, 3'd2, 2'b01, 2'b00);

      // Early WLAST: SLVERR but data still written
      for (int i = 0; i < 4; i++) begin wdat[i] = 32'h51 + 32'(i); rexp[i] = 32'h51 + 32'(i); end
      wr(4'd5, 16'h0200, 8'd3, 3'd2, 2'b01, 4'hF, 1, 2'b10);
      rd(4'd5, 16'h0200, 8'd3, 3'd2, 2'b01, 2'b00);

      // Reset during beat 2 of a burst aborts it
      for (int i = 0; i < 4; i++) wdat[i] = 32'hC0 + 32'(i);
      wr(4'd6, 16'h0300, 8'd3, 3'd2, 2'b01, 4'hF, 3, 2'b00);
      AWID = 4'd7; AWADDR = 16'h0300; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
      @(negedge ACLK);
      AWVALID = 1'b0;
      for (int i = 0; i < 2; i++) begin
         WDATA = 32'hE0 + 32'(i); WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
         @(negedge ACLK);
      end
      WDATA = 32'hE2; WVALID = 1'b1; ARESET = 1'b1;
      @(negedge ACLK);
      WVALID = 1'b0; ARESET = 1'b0;
      chk("abort_awready", 64'(AWREADY), 64'd1);
      chk("abort_arready", 64'(ARREADY), 64'd1);
      chk("abort_bvalid", 64'(BVALID), 64'd0);
      chk("abort_wready", 64'(WREADY), 64'd0);
      @(negedge ACLK);
      chk("abort_bvalid_later", 64'(BVALID), 64'd0);
      rexp[0] = 32'hE0; rexp[1] = 32'hE1; rexp[2] = 32'hC2; rexp[3] = 32'hC3;
      rd(4'd7, 16'h0300, 8'd3, 3'd2, 2'b01, 2'b00);

      // 256-beat INCR burst
      for (int i = 0; i < 256; i++) begin wdat[i] = 32'h1000 + 32'(i); rexp[i] = 32'h1000 + 32'(i); end
      wr(4'd15, 16'h0400, 8'd255, 3'd2, 2'b01, 4'hF, 255, 2'b00);
      rd(4'd14, 16'h0400, 8'd255, 3'd2, 2'b01, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
